// File: rtl/readout_rx_decision_scheduler.sv
// Shared threshold decision stage for NUM_CHANNEL readout channels: latches finished bin counts,
// arbitrates them round-robin and emits one tagged state decision per cycle over valid/ready.
module readout_rx_decision_scheduler #(
  parameter int NUM_CHANNEL       = 4,
  parameter int BIN_COUNTER_WIDTH = 16,
  parameter int CH_ID_WIDTH       = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CHANNEL*BIN_COUNTER_WIDTH-1:0] bin_count_in,
  input  logic [NUM_CHANNEL-1:0]                 finish_count_in,
  input  logic                                   cfg_we_in,
  input  logic [CH_ID_WIDTH-1:0]                 cfg_ch_in,
  input  logic [BIN_COUNTER_WIDTH-1:0]           cfg_threshold_in,
  input  logic                                   overrun_clr_in,
  input  logic                                   ready_in,
  output logic                                   valid_meas_result_out,
  output logic                                   meas_result_out,
  output logic [CH_ID_WIDTH-1:0]                 meas_ch_out,
  output logic [NUM_CHANNEL-1:0]                 overrun_out
);

  localparam int W = BIN_COUNTER_WIDTH;
  localparam logic [W-1:0] THR_RST = {1'b1, {(W-1){1'b0}}};

  // Counts and thresholds are magnitudes, so the decision is an unsigned full-width compare.
  function automatic logic decide(input logic [W-1:0] cnt, input logic [W-1:0] thr);
    return (cnt >= thr);
  endfunction

  logic [W-1:0]           hold_p0 [NUM_CHANNEL];
  logic [W-1:0]           thr_p0  [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0] pending_p0;
  logic [NUM_CHANNEL-1:0] overrun_p0;
  logic [CH_ID_WIDTH-1:0] rr_ptr;

  logic                   vld_p1;
  logic                   result_p1;
  logic [CH_ID_WIDTH-1:0] ch_p1;

  logic                   grant_vld;
  logic [NUM_CHANNEL-1:0] grant_oh;
  logic [CH_ID_WIDTH-1:0] grant_ch;
  logic [W-1:0]           grant_hold;
  logic [W-1:0]           grant_thr;
  logic [CH_ID_WIDTH-1:0] rr_next;
  logic                   advance;
  logic                   do_grant;
  logic [NUM_CHANNEL-1:0] grant_clr;
  logic [NUM_CHANNEL-1:0] capture;
  logic [NUM_CHANNEL-1:0] lost;

  // Search order starts at rr_ptr and wraps; the first pending channel in that order wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_oh   = '0;
    grant_ch   = '0;
    grant_hold = '0;
    grant_thr  = '0;
    rr_next    = rr_ptr;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      for (int k = 0; k < NUM_CHANNEL; k++) begin
        if (!grant_vld && pending_p0[k] && (((int'(rr_ptr) + i) % NUM_CHANNEL) == k)) begin
          grant_vld   = 1'b1;
          grant_oh[k] = 1'b1;
          grant_ch    = CH_ID_WIDTH'(k);
          grant_hold  = hold_p0[k];
          grant_thr   = thr_p0[k];
          rr_next     = (k == NUM_CHANNEL - 1) ? '0 : CH_ID_WIDTH'(k + 1);
        end
      end
    end
  end

  assign advance   = !vld_p1 || ready_in;
  assign do_grant  = advance && grant_vld;
  assign grant_clr = grant_oh & {NUM_CHANNEL{do_grant}};
  assign capture   = finish_count_in & (~pending_p0 | grant_clr);
  assign lost      = finish_count_in & pending_p0 & ~grant_clr;

  // Stage p0 -> p1: capture/arbitrate, decide, load output slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_p0 <= '0;
      overrun_p0 <= '0;
      rr_ptr     <= '0;
      vld_p1     <= 1'b0;
      result_p1  <= 1'b0;
      ch_p1      <= '0;
      for (int k = 0; k < NUM_CHANNEL; k++) thr_p0[k] <= THR_RST;
    end else begin
      pending_p0 <= (pending_p0 & ~grant_clr) | capture;
      // A fresh overrun wins over a same-edge clear so no lost result goes unreported.
      overrun_p0 <= (overrun_p0 & {NUM_CHANNEL{!overrun_clr_in}}) | lost;
      for (int k = 0; k < NUM_CHANNEL; k++) begin
        if (cfg_we_in && (int'(cfg_ch_in) == k)) thr_p0[k] <= cfg_threshold_in;
      end
      if (advance) begin
        vld_p1    <= grant_vld;
        result_p1 <= grant_vld && decide(grant_hold, grant_thr);
        ch_p1     <= grant_ch;
      end
      if (do_grant) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      if (capture[k]) hold_p0[k] <= bin_count_in[k*W +: W];
    end
  end

  assign valid_meas_result_out = vld_p1;
  assign meas_result_out       = result_p1;
  assign meas_ch_out           = ch_p1;
  assign overrun_out           = overrun_p0;

endmodule

// File: tb/tb_readout_rx_decision_scheduler.sv
// Directed bench for readout_rx_decision_scheduler: table-driven single decisions and bursts,
// plus hand-written backpressure, overrun, same-edge and mid-burst reset sequences.
module tb_readout_rx_decision_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] bin_count_in;
  logic [3:0]  finish_count_in;
  logic        cfg_we_in;
  logic [1:0]  cfg_ch_in;
  logic [15:0] cfg_threshold_in;
  logic        overrun_clr_in;
  logic        ready_in;
  logic        valid_meas_result_out;
  logic        meas_result_out;
  logic [1:0]  meas_ch_out;
  logic [3:0]  overrun_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          ch;
    logic [15:0] cnt;
    logic        res;
  } single_t;

  single_t stab [5];

  readout_rx_decision_scheduler #(
    .NUM_CHANNEL(4), .BIN_COUNTER_WIDTH(16), .CH_ID_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .bin_count_in(bin_count_in), .finish_count_in(finish_count_in),
    .cfg_we_in(cfg_we_in), .cfg_ch_in(cfg_ch_in), .cfg_threshold_in(cfg_threshold_in),
    .overrun_clr_in(overrun_clr_in), .ready_in(ready_in),
    .valid_meas_result_out(valid_meas_result_out), .meas_result_out(meas_result_out),
    .meas_ch_out(meas_ch_out), .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [1:0] ch, input logic r);
    chk({nm, " valid"}, 32'(valid_meas_result_out), 32'(v));
    chk({nm, " ch"}, 32'(meas_ch_out), 32'(ch));
    chk({nm, " result"}, 32'(meas_result_out), 32'(r));
  endtask

  task automatic run_single(input int ch, input logic [15:0] cnt, input logic res, input string nm);
    ready_in = 1'b1;
    bin_count_in[ch*16 +: 16] = cnt;
    finish_count_in = 4'b0;
    finish_count_in[ch] = 1'b1;
    tick();
    finish_count_in = 4'b0;
    chk({nm, " latency"}, 32'(valid_meas_result_out), 32'd0);
    tick();
    chk_out(nm, 1'b1, 2'(ch), res);
    tick();
    chk({nm, " drain"}, 32'(valid_meas_result_out), 32'd0);
  endtask

  task automatic run_burst(input logic [15:0] cnt, input logic [3:0] exp, input string nm);
    ready_in = 1'b1;
    bin_count_in = {4{cnt}};
    finish_count_in = 4'hF;
    tick();
    finish_count_in = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("%s #%0d", nm, k), 1'b1, 2'(k), exp[k]);
    end
    tick();
    chk({nm, " drain"}, 32'(valid_meas_result_out), 32'd0);
  endtask

  initial begin
    stab[0] = '{0, 16'h8000, 1'b1};
    stab[1] = '{0, 16'h7FFF, 1'b0};
    stab[2] = '{2, 16'h8001, 1'b1};
    stab[3] = '{1, 16'hFFFF, 1'b1};
    stab[4] = '{3, 16'h0000, 1'b0};

    rst = 1'b0;
    bin_count_in = '0;
    finish_count_in = '0;
    cfg_we_in = 1'b0;
    cfg_ch_in = '0;
    cfg_threshold_in = '0;
    overrun_clr_in = 1'b0;
    ready_in = 1'b1;
    #12;
    chk_out("reset", 1'b0, 2'd0, 1'b0);
    chk("reset overrun", 32'(overrun_out), 32'd0);
    rst = 1'b1;
    tick();

    // Default thresholds of 0x8000
    for (int i = 0; i < 5; i++) run_single(stab[i].ch, stab[i].cnt, stab[i].res, $sformatf("dflt%0d", i));

    // Programmed thresholds and round-robin bursts
    for (int k = 0; k < 4; k++) begin
      cfg_we_in = 1'b1;
      cfg_ch_in = 2'(k);
      cfg_threshold_in = 16'((k + 1) * 100);
      tick();
    end
    cfg_we_in = 1'b0;
    run_burst(16'd250, 4'b0011, "burst250");
    run_burst(16'd300, 4'b0111, "burst300");

    // Backpressure: ch1 and ch2 pending, ready low
    ready_in = 1'b0;
    bin_count_in[16 +: 16] = 16'd150;
    bin_count_in[32 +: 16] = 16'd350;
    finish_count_in = 4'b0110;
    tick();
    finish_count_in = 4'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk_out($sformatf("stall%0d", c), 1'b1, 2'd1, 1'b0);
      tick();
    end
    chk_out("stall end", 1'b1, 2'd1, 1'b0);
    ready_in = 1'b1;
    tick();
    chk_out("release ch2", 1'b1, 2'd2, 1'b1);
    tick();
    chk("no duplicate", 32'(valid_meas_result_out), 32'd0);

    // Overrun on ch3 while the slot is stalled on ch0
    ready_in = 1'b0;
    bin_count_in[0 +: 16] = 16'd500;
    finish_count_in = 4'b0001;
    tick();
    finish_count_in = 4'b0;
    tick();
    chk_out("ovr hold ch0", 1'b1, 2'd0, 1'b1);
    cfg_we_in = 1'b1;
    cfg_ch_in = 2'd3;
    cfg_threshold_in = 16'd15;
    bin_count_in[48 +: 16] = 16'd10;
    finish_count_in = 4'b1000;
    tick();
    cfg_we_in = 1'b0;
    chk("ovr first capture", 32'(overrun_out), 32'd0);
    bin_count_in[48 +: 16] = 16'd20;
    overrun_clr_in = 1'b1;
    tick();
    finish_count_in = 4'b0;
    overrun_clr_in = 1'b0;
    chk("ovr set over clear", 32'(overrun_out), 32'h8);
    chk_out("ovr still ch0", 1'b1, 2'd0, 1'b1);
    ready_in = 1'b1;
    tick();
    chk_out("ovr ch3 old count", 1'b1, 2'd3, 1'b0);
    tick();
    chk("ovr drain", 32'(valid_meas_result_out), 32'd0);
    chk("ovr sticky", 32'(overrun_out), 32'h8);
    overrun_clr_in = 1'b1;
    tick();
    overrun_clr_in = 1'b0;
    chk("ovr cleared", 32'(overrun_out), 32'd0);

    // Same-edge grant, capture and threshold write on ch2
    bin_count_in[32 +: 16] = 16'd350;
    finish_count_in = 4'b0100;
    tick();
    bin_count_in[32 +: 16] = 16'd450;
    cfg_we_in = 1'b1;
    cfg_ch_in = 2'd2;
    cfg_threshold_in = 16'd400;
    tick();
    finish_count_in = 4'b0;
    cfg_we_in = 1'b0;
    chk_out("same-edge first", 1'b1, 2'd2, 1'b1);
    chk("same-edge no overrun", 32'(overrun_out), 32'd0);
    tick();
    chk_out("same-edge second", 1'b1, 2'd2, 1'b1);
    tick();
    chk("same-edge drain", 32'(valid_meas_result_out), 32'd0);

    // Asynchronous reset mid-burst
    bin_count_in = {4{16'd250}};
    finish_count_in = 4'hF;
    tick();
    finish_count_in = 4'h0;
    tick();
    chk_out("pre-reset", 1'b1, 2'd3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 2'd0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("no stale %0d", c), 32'(valid_meas_result_out), 32'd0);
    end
    for (int i = 0; i < 5; i++) run_single(stab[i].ch, stab[i].cnt, stab[i].res, $sformatf("post-rst%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
